// File: rtl/md_step_sequencer_pkg.sv
// Shared state encoding and defaults for the MD timestep sequencer.
// The numeric encoding is visible to software through MD_state.
package md_step_sequencer_pkg;

  localparam int unsigned MD_STATE_W         = 3;
  localparam int unsigned DEFAULT_STEP_WIDTH = 32;

  typedef enum logic [MD_STATE_W-1:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StForce  = 3'd2,
    StMotion = 3'd3,
    StDrain  = 3'd4,
    StDone   = 3'd5,
    StError  = 3'd6
  } md_state_e;

  // Phases that wait on a datapath unit and are therefore guarded by the watchdog
  function automatic logic is_busy(input md_state_e s);
    return (s == StLoad) || (s == StForce) || (s == StMotion) || (s == StDrain);
  endfunction

endpackage

// File: rtl/md_step_sequencer_watchdog.sv
// Progress watchdog: expires after TIMEOUT_CYCLES enabled cycles without a progress event.
// A TIMEOUT_CYCLES of 0 disables it entirely.
module md_step_sequencer_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic progress,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LastVal = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] Last = CW'(LastVal);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear || progress || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q != Last) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th idle cycle
  assign expired = (TIMEOUT_CYCLES != 0) && enable && !clear && !progress && (cnt_q == Last);

endmodule

// File: rtl/md_step_sequencer.sv
// Timestep scheduler: host load -> (force -> motion) x iter_target -> k2h drain.
// Emits one-cycle phase start pulses and traps stalled phases via a watchdog.
module md_step_sequencer
  import md_step_sequencer_pkg::*;
#(
  parameter int unsigned STEP_WIDTH     = DEFAULT_STEP_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  input  logic                  abort,
  input  logic [STEP_WIDTH-1:0] iter_target,
  input  logic [STEP_WIDTH-1:0] load_count,
  input  logic                  load_valid,
  output logic                  force_start,
  input  logic                  force_done,
  output logic                  motion_start,
  input  logic                  motion_done,
  output logic                  drain_start,
  input  logic                  drain_beat,
  input  logic                  drain_last,
  output logic [MD_STATE_W-1:0] MD_state,
  output logic [STEP_WIDTH-1:0] step,
  output logic [STEP_WIDTH-1:0] out_count,
  output logic                  ap_idle,
  output logic                  ap_done,
  output logic                  err_timeout
);

  md_state_e             state_q;
  logic [STEP_WIDTH-1:0] iter_q;
  logic [STEP_WIDTH-1:0] load_q;
  logic [STEP_WIDTH-1:0] load_cnt_q;
  logic [STEP_WIDTH-1:0] load_cnt_inc;
  logic [STEP_WIDTH-1:0] step_inc;
  logic                  busy;
  logic                  progress;
  logic                  wd_expired;

  assign load_cnt_inc = load_cnt_q + 1'b1;
  assign step_inc     = step + 1'b1;
  assign busy         = is_busy(state_q);
  assign MD_state     = state_q;

  // Only in-phase handshakes count as progress; strays must not feed the watchdog
  assign progress = ((state_q == StLoad)   && load_valid)  ||
                    ((state_q == StForce)  && force_done)  ||
                    ((state_q == StMotion) && motion_done) ||
                    ((state_q == StDrain)  && drain_beat);

  md_step_sequencer_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .clear   (abort || !busy),
    .enable  (busy),
    .progress(progress),
    .expired (wd_expired)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      iter_q       <= '0;
      load_q       <= '0;
      load_cnt_q   <= '0;
      step         <= '0;
      out_count    <= '0;
      force_start  <= 1'b0;
      motion_start <= 1'b0;
      drain_start  <= 1'b0;
      ap_idle      <= 1'b1;
      ap_done      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      force_start  <= 1'b0;
      motion_start <= 1'b0;
      drain_start  <= 1'b0;
      if (abort) begin
        state_q     <= StIdle;
        load_cnt_q  <= '0;
        step        <= '0;
        out_count   <= '0;
        ap_idle     <= 1'b1;
        ap_done     <= 1'b0;
        err_timeout <= 1'b0;
      end else if (wd_expired) begin
        state_q     <= StError;
        ap_idle     <= 1'b1;
        ap_done     <= 1'b0;
        err_timeout <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (ap_start) begin
              iter_q     <= iter_target;
              load_q     <= load_count;
              load_cnt_q <= '0;
              step       <= '0;
              out_count  <= '0;
              if (iter_target == '0 || load_count == '0) begin
                state_q <= StDone;
                ap_idle <= 1'b1;
                ap_done <= 1'b1;
              end else begin
                state_q <= StLoad;
                ap_idle <= 1'b0;
                ap_done <= 1'b0;
              end
            end
          end
          StLoad: begin
            if (load_valid) begin
              load_cnt_q <= load_cnt_inc;
              if (load_cnt_inc == load_q) begin
                state_q     <= StForce;
                force_start <= 1'b1;
              end
            end
          end
          StForce: begin
            if (force_done) begin
              state_q      <= StMotion;
              motion_start <= 1'b1;
            end
          end
          StMotion: begin
            if (motion_done) begin
              step <= step_inc;
              if (step_inc == iter_q) begin
                state_q     <= StDrain;
                drain_start <= 1'b1;
              end else begin
                state_q     <= StForce;
                force_start <= 1'b1;
              end
            end
          end
          StDrain: begin
            if (drain_beat) begin
              out_count <= out_count + 1'b1;
              if (drain_last) begin
                state_q <= StDone;
                ap_idle <= 1'b1;
                ap_done <= 1'b1;
              end
            end
          end
          StError: begin
            state_q <= StError;
          end
          default: begin
            state_q <= StIdle;
            ap_idle <= 1'b1;
            ap_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_md_step_sequencer.sv
// Bench for md_step_sequencer: table-driven start vectors, hand-written corner
// sequences and randomized runs checked against a run-level reference model.
module tb_md_step_sequencer;

  localparam int unsigned SW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          ap_start, abort, load_valid, force_done, motion_done, drain_beat, drain_last;
  logic [SW-1:0] iter_target, load_count;
  logic          force_start, motion_start, drain_start;
  logic [2:0]    md_state;
  logic [SW-1:0] step, out_count;
  logic          ap_idle, ap_done, err_timeout;

  md_step_sequencer #(
    .STEP_WIDTH    (SW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ap_clk      (clk),
    .ap_rst      (rst),
    .ap_start    (ap_start),
    .abort       (abort),
    .iter_target (iter_target),
    .load_count  (load_count),
    .load_valid  (load_valid),
    .force_start (force_start),
    .force_done  (force_done),
    .motion_start(motion_start),
    .motion_done (motion_done),
    .drain_start (drain_start),
    .drain_beat  (drain_beat),
    .drain_last  (drain_last),
    .MD_state    (md_state),
    .step        (step),
    .out_count   (out_count),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .err_timeout (err_timeout)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_force, n_motion, n_drain;
  int trace[$];
  int prev_state = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [SW-1:0] iter;
    logic [SW-1:0] load;
    int            exp_state;
    bit            exp_done;
    bit            exp_idle;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A start pulse must appear exactly when its phase first becomes visible
  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_on) begin
      check("force_start_coherent", force_start, (md_state == 3'd2) && (prev_state != 2));
      check("motion_start_coherent", motion_start, (md_state == 3'd3) && (prev_state != 3));
      check("drain_start_coherent", drain_start, (md_state == 3'd4) && (prev_state != 4));
      if (force_start) n_force++;
      if (motion_start) n_motion++;
      if (drain_start) n_drain++;
      if (int'(md_state) != prev_state) trace.push_back(int'(md_state));
    end
    prev_state = int'(md_state);
  endtask

  task automatic clear_inputs();
    ap_start = 0; abort = 0; load_valid = 0; force_done = 0;
    motion_done = 0; drain_beat = 0; drain_last = 0;
  endtask

  // Idle cycles inside a phase with random out-of-phase handshakes that must be ignored
  task automatic gap(input int phase, input int n);
    for (int i = 0; i < n; i++) begin
      ap_start    = ($urandom_range(0, 3) == 0);
      load_valid  = (phase != 1) && ($urandom_range(0, 3) == 0);
      force_done  = (phase != 2) && ($urandom_range(0, 3) == 0);
      motion_done = (phase != 3) && ($urandom_range(0, 3) == 0);
      drain_beat  = (phase != 4) && ($urandom_range(0, 3) == 0);
      drain_last  = ($urandom_range(0, 3) == 0);
      tick();
      clear_inputs();
      check("gap_state_hold", md_state, phase);
    end
  endtask

  function automatic int pick_delay(input int delay);
    return (delay < 0) ? int'($urandom_range(0, 5)) : delay;
  endfunction

  task automatic run(input int nload, input int niter, input int nbeats, input int delay);
    int exp_trace[$];
    trace.delete();
    n_force = 0; n_motion = 0; n_drain = 0;
    iter_target = SW'(niter);
    load_count  = SW'(nload);
    ap_start    = 1;
    tick();
    ap_start    = 0;
    iter_target = $urandom;   // latched values must not follow the port afterwards
    load_count  = $urandom;
    check("run_enter_load", md_state, 1);
    for (int i = 0; i < nload; i++) begin
      gap(1, pick_delay(delay));
      load_valid = 1;
      tick();
      load_valid = 0;
    end
    for (int s = 0; s < niter; s++) begin
      gap(2, pick_delay(delay));
      force_done = 1;
      tick();
      force_done = 0;
      gap(3, pick_delay(delay));
      motion_done = 1;
      tick();
      motion_done = 0;
      check("run_step", step, s + 1);
    end
    for (int b = 0; b < nbeats; b++) begin
      gap(4, pick_delay(delay));
      drain_beat = 1;
      drain_last = (b == nbeats - 1);
      tick();
      drain_beat = 0;
      drain_last = 0;
      check("run_out_count", out_count, b + 1);
    end
    exp_trace.push_back(1);
    for (int s = 0; s < niter; s++) begin
      exp_trace.push_back(2);
      exp_trace.push_back(3);
    end
    exp_trace.push_back(4);
    exp_trace.push_back(5);
    check("run_final_state", md_state, 5);
    check("run_ap_done", ap_done, 1);
    check("run_ap_idle", ap_idle, 1);
    check("run_final_step", step, niter);
    check("run_final_out_count", out_count, nbeats);
    check("run_n_force", n_force, niter);
    check("run_n_motion", n_motion, niter);
    check("run_n_drain", n_drain, 1);
    check("run_trace_len", trace.size(), exp_trace.size());
    for (int i = 0; i < exp_trace.size() && i < trace.size(); i++)
      check("run_trace_state", trace[i], exp_trace[i]);
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  initial begin
    vec_t vecs[5];
    vecs[0] = '{iter: 0, load: 4, exp_state: 5, exp_done: 1, exp_idle: 1};
    vecs[1] = '{iter: 3, load: 0, exp_state: 5, exp_done: 1, exp_idle: 1};
    vecs[2] = '{iter: 0, load: 0, exp_state: 5, exp_done: 1, exp_idle: 1};
    vecs[3] = '{iter: 2, load: 3, exp_state: 1, exp_done: 0, exp_idle: 0};
    vecs[4] = '{iter: 1, load: 1, exp_state: 1, exp_done: 0, exp_idle: 0};

    clear_inputs();
    iter_target = '0;
    load_count  = '0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    check("reset_state", md_state, 0);
    check("reset_step", step, 0);
    check("reset_out_count", out_count, 0);
    check("reset_ap_idle", ap_idle, 1);
    check("reset_ap_done", ap_done, 0);
    check("reset_err", err_timeout, 0);
    check("reset_pulses", {force_start, motion_start, drain_start}, 0);
    mon_on = 1;

    // Start vectors, including the zero-length guards that jump straight to DONE
    foreach (vecs[i]) begin
      iter_target = vecs[i].iter;
      load_count  = vecs[i].load;
      ap_start    = 1;
      tick();
      ap_start    = 0;
      check("vec_state", md_state, vecs[i].exp_state);
      check("vec_ap_done", ap_done, vecs[i].exp_done);
      check("vec_ap_idle", ap_idle, vecs[i].exp_idle);
      check("vec_step", step, 0);
      do_abort();
      check("vec_abort_idle", md_state, 0);
    end

    // Nominal run with a fixed 5-cycle driver response, then an immediate restart from DONE
    run(4, 3, 3, 5);
    run(2, 1, 1, 0);

    // Abort while in MOTION at step 1
    do_abort();
    iter_target = 3;
    load_count  = 2;
    ap_start = 1; tick(); ap_start = 0;
    load_valid = 1; tick(); tick(); load_valid = 0;
    force_done = 1; tick(); force_done = 0;
    motion_done = 1; tick(); motion_done = 0;
    force_done = 1; tick(); force_done = 0;
    check("abort_pre_state", md_state, 3);
    check("abort_pre_step", step, 1);
    do_abort();
    check("abort_state", md_state, 0);
    check("abort_step", step, 0);
    check("abort_ap_idle", ap_idle, 1);
    check("abort_ap_done", ap_done, 0);
    check("abort_pulses", {force_start, motion_start, drain_start}, 0);
    run(2, 2, 2, -1);

    // Watchdog: withhold force_done until the timeout lands exactly TO cycles after entry
    do_abort();
    iter_target = 1;
    load_count  = 1;
    ap_start = 1; tick(); ap_start = 0;
    load_valid = 1; tick(); load_valid = 0;
    check("wd_force_entry", md_state, 2);
    for (int i = 0; i < int'(TO) - 1; i++) tick();
    check("wd_before_expiry", md_state, 2);
    tick();
    check("wd_error_state", md_state, 6);
    check("wd_err_timeout", err_timeout, 1);
    check("wd_ap_idle", ap_idle, 1);
    check("wd_ap_done", ap_done, 0);
    ap_start = 1; tick(); tick(); ap_start = 0;
    check("wd_start_ignored", md_state, 6);
    do_abort();
    check("wd_abort_state", md_state, 0);
    check("wd_abort_err", err_timeout, 0);

    // Synchronous reset mid-DRAIN with a beat in flight
    iter_target = 1;
    load_count  = 1;
    ap_start = 1; tick(); ap_start = 0;
    load_valid = 1; tick(); load_valid = 0;
    force_done = 1; tick(); force_done = 0;
    motion_done = 1; tick(); motion_done = 0;
    check("rst_pre_drain", md_state, 4);
    drain_beat = 1;
    rst = 1;
    tick();
    rst = 0;
    drain_beat = 0;
    check("rst_state", md_state, 0);
    check("rst_step", step, 0);
    check("rst_out_count", out_count, 0);
    check("rst_ap_idle", ap_idle, 1);
    check("rst_ap_done", ap_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_pulses", {force_start, motion_start, drain_start}, 0);

    // Randomized runs with stray handshakes sprinkled through every phase
    for (int r = 0; r < 20; r++) begin
      run($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(1, 4), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
